// File: rtl/uart_fpu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_fpu_sequencer
//
// Top-level scheduler of the UART test harness. It collects one operand A and
// one operand B from the UART receive path (in either order), launches a single
// FPU operation, and waits a bounded number of cycles for the result. It then
// sends the result MSB-first, one byte at a time, to the UART transmitter using
// a start/done handshake.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_done_a      one-cycle pulse, i_data_a valid
//   i_data_a      operand A word
//   i_done_b      one-cycle pulse, i_data_b valid
//   i_data_b      operand B word
//   o_fpu_start   one-cycle FPU launch pulse
//   o_fpu_a       latched operand A (stable until the next capture)
//   o_fpu_b       latched operand B (stable until the next capture)
//   i_fpu_valid   one-cycle pulse, i_fpu_result valid
//   i_fpu_result  FPU result word
//   o_tx_start    one-cycle pulse, transmit o_tx_data
//   o_tx_data     byte to transmit (held while waiting for i_tx_done)
//   i_tx_done     one-cycle pulse, byte fully sent
//   o_busy        high in every state except IDLE
//   o_timeout     one-cycle pulse when the FPU result never arrived
//   o_drop        one-cycle pulse when an operand pulse was ignored
// -----------------------------------------------------------------------------
module uart_fpu_sequencer #(
  parameter int SIZE_DATA      = 32,
  parameter int SIZE_BYTE      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_done_a,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic                 i_done_b,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_fpu_start,
  output logic [SIZE_DATA-1:0] o_fpu_a,
  output logic [SIZE_DATA-1:0] o_fpu_b,
  input  logic                 i_fpu_valid,
  input  logic [SIZE_DATA-1:0] i_fpu_result,
  output logic                 o_tx_start,
  output logic [SIZE_BYTE-1:0] o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic                 o_drop
);

  localparam int NBYTES = SIZE_DATA / SIZE_BYTE;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_FPU = 3'd2,
    S_SEND     = 3'd3,
    S_WAIT_TX  = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_have_a;
  logic                 r_have_b;
  logic [SIZE_DATA-1:0] r_result;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;

  logic [SIZE_BYTE-1:0] w_bytes [NBYTES];
  logic [IDX_W-1:0]     w_idx_inc;
  logic [SIZE_BYTE-1:0] w_first_byte;

  // Byte k of the latched result, most significant byte first.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign w_bytes[gi] = r_result[SIZE_DATA-1-gi*SIZE_BYTE -: SIZE_BYTE];
    end
  endgenerate

  assign w_idx_inc    = r_idx + IDX_W'(1);
  // The first byte comes straight from the FPU bus so o_tx_start can follow
  // i_fpu_valid by a single cycle.
  assign w_first_byte = i_fpu_result[SIZE_DATA-1 -: SIZE_BYTE];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_have_a    <= 1'b0;
      r_have_b    <= 1'b0;
      r_result    <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      o_fpu_start <= 1'b0;
      o_fpu_a     <= '0;
      o_fpu_b     <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      // Pulse outputs default low; each branch raises them for one cycle.
      o_fpu_start <= 1'b0;
      o_tx_start  <= 1'b0;
      o_timeout   <= 1'b0;
      o_drop      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_done_a) begin
            o_fpu_a  <= i_data_a;
            r_have_a <= 1'b1;
          end
          if (i_done_b) begin
            o_fpu_b  <= i_data_b;
            r_have_b <= 1'b1;
          end
          // Decision uses the flags as they stood before this edge, so the
          // launch always comes one cycle after the pair is complete.
          if (r_have_a && r_have_b) begin
            r_state     <= S_ISSUE;
            o_fpu_start <= 1'b1;
            o_busy      <= 1'b1;
          end
        end

        S_ISSUE: begin
          r_have_a <= 1'b0;
          r_have_b <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_WAIT_FPU;
        end

        S_WAIT_FPU: begin
          // A result arriving on the limit cycle still wins over the timeout.
          if (i_fpu_valid) begin
            r_result   <= i_fpu_result;
            r_idx      <= '0;
            o_tx_data  <= w_first_byte;
            o_tx_start <= 1'b1;
            r_state    <= S_SEND;
          end else if (r_cnt == CNT_LIMIT) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_SEND: begin
          r_state <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (i_tx_done) begin
            if (r_idx == LAST_IDX) begin
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx      <= w_idx_inc;
              o_tx_data  <= w_bytes[w_idx_inc];
              o_tx_start <= 1'b1;
              r_state    <= S_SEND;
            end
          end
        end

        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      // Operands can only be accepted in IDLE; anything else is reported.
      if ((r_state != S_IDLE) && (i_done_a || i_done_b)) begin
        o_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_fpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_fpu_sequencer
//
// Directed bench for uart_fpu_sequencer (32-bit words, 8-bit bytes, a 16-cycle
// FPU timeout). A transaction-level model predicts every output on every cycle;
// directed scenarios add hand-computed literal expectations (latencies, byte
// sequences, pulse counts).
// -----------------------------------------------------------------------------
module tb_uart_fpu_sequencer;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        done_a, done_b, fpu_valid, tx_done;
  logic [31:0] data_a, data_b, fpu_result;
  logic        o_fpu_start, o_tx_start, o_busy, o_timeout, o_drop;
  logic [31:0] o_fpu_a, o_fpu_b;
  logic [7:0]  o_tx_data;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  int cnt_start = 0, cnt_txs = 0, cnt_drop = 0, cnt_to = 0;
  logic [7:0] tx_log[$];

  uart_fpu_sequencer #(
    .SIZE_DATA(32), .SIZE_BYTE(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_done_a(done_a), .i_data_a(data_a),
    .i_done_b(done_b), .i_data_b(data_b),
    .o_fpu_start(o_fpu_start), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b),
    .i_fpu_valid(fpu_valid), .i_fpu_result(fpu_result),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(tx_done),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_drop(o_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: operands pair up in idle, a launch opens a
  // TO-cycle result window, a result turns into a queue of bytes that are
  // released one per acknowledged byte.
  // ---------------------------------------------------------------------------
  int         k = 0;
  bit         m_busy, m_have_a, m_have_b, m_sending;
  int         m_launch, m_last_tx;
  logic [31:0] m_a, m_b;
  logic [7:0]  m_txdata;
  logic [7:0]  m_q[$];
  bit         m_start, m_txs, m_drop, m_to;

  initial begin
    bit launch_now;
    logic [31:0] res;
    forever begin
      @(posedge clk);
      k++;
      m_start = 0; m_txs = 0; m_drop = 0; m_to = 0;
      if (!rst_n) begin
        m_busy = 0; m_have_a = 0; m_have_b = 0; m_sending = 0;
        m_a = '0; m_b = '0; m_txdata = '0; m_q.delete();
        m_launch = 0; m_last_tx = 0;
      end else if (!m_busy) begin
        launch_now = m_have_a && m_have_b;
        if (done_a) begin m_a = data_a; m_have_a = 1; end
        if (done_b) begin m_b = data_b; m_have_b = 1; end
        if (launch_now) begin
          m_busy = 1; m_start = 1; m_launch = k; m_sending = 0;
          m_have_a = 0; m_have_b = 0;
        end
      end else begin
        if (done_a || done_b) m_drop = 1;
        if (!m_sending) begin
          if (k >= m_launch + 2 && fpu_valid) begin
            res = fpu_result;
            m_q.delete();
            for (int i = 0; i < 4; i++) m_q.push_back(res[31-8*i -: 8]);
            m_txdata = m_q.pop_front();
            m_txs = 1; m_sending = 1; m_last_tx = k;
          end else if (k == m_launch + 1 + TO) begin
            m_to = 1; m_busy = 0;
          end
        end else if (k >= m_last_tx + 2 && tx_done) begin
          if (m_q.size() == 0) begin
            m_busy = 0;
          end else begin
            m_txdata = m_q.pop_front();
            m_txs = 1; m_last_tx = k;
          end
        end
      end
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (!rst_n) begin
          check("rst_fpu_start", o_fpu_start, 0);
          check("rst_tx_start", o_tx_start, 0);
          check("rst_busy", o_busy, 0);
          check("rst_fpu_a", o_fpu_a, 0);
          check("rst_tx_data", o_tx_data, 0);
        end else begin
          check("cyc_fpu_start", o_fpu_start, m_start);
          check("cyc_tx_start", o_tx_start, m_txs);
          check("cyc_drop", o_drop, m_drop);
          check("cyc_timeout", o_timeout, m_to);
          check("cyc_busy", o_busy, m_busy);
          check("cyc_fpu_a", o_fpu_a, m_a);
          check("cyc_fpu_b", o_fpu_b, m_b);
          check("cyc_tx_data", o_tx_data, m_txdata);
          if (o_fpu_start) cnt_start++;
          if (o_tx_start) begin cnt_txs++; tx_log.push_back(o_tx_data); end
          if (o_drop) cnt_drop++;
          if (o_timeout) cnt_to++;
        end
      end
    end
  end

  // UART transmitter stand-in: acknowledges each byte 3 cycles after its start.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start && rst_n) begin
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic pulse_a(input logic [31:0] d);
    @(posedge clk); #1 done_a = 1; data_a = d;
    @(posedge clk); #1 done_a = 0;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    @(posedge clk); #1 done_b = 1; data_b = d;
    @(posedge clk); #1 done_b = 0;
  endtask

  task automatic pulse_ab(input logic [31:0] da, input logic [31:0] db);
    @(posedge clk); #1 done_a = 1; data_a = da; done_b = 1; data_b = db;
    @(posedge clk); #1 done_a = 0; done_b = 0;
  endtask

  // Call from the falling edge of the o_fpu_start cycle; valid is sampled
  // d+1 rising edges after the launch edge.
  task automatic fpu_reply(input int d, input logic [31:0] r);
    repeat (d) @(posedge clk);
    #1 fpu_valid = 1; fpu_result = r;
    @(posedge clk); #1 fpu_valid = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_fpu_start && n < 50);
    check("start_seen", o_fpu_start, 1);
  endtask

  task automatic wait_txs();
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_tx_start && n < 50);
    check("tx_start_seen", o_tx_start, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (o_busy && n < 200);
    check("idle_reached", o_busy, 0);
  endtask

  task automatic check_log(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e[4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    check("tx_byte_count", tx_log.size(), 4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++) check("tx_byte", tx_log[i], e[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int s0, t0, d0, o0, n, nd;
    rst_n = 1; done_a = 0; done_b = 0; fpu_valid = 0;
    data_a = '0; data_b = '0; fpu_result = '0;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", o_busy, 0);
    check("reset_fpu_a", o_fpu_a, 0);
    check("reset_fpu_start", o_fpu_start, 0);
    check("reset_tx_data", o_tx_data, 0);
    chk_en = 1;
    @(posedge clk); #1 rst_n = 1;

    // A then B five cycles later; result 3.0
    tx_log.delete(); s0 = cnt_start; t0 = cnt_txs;
    pulse_a(32'h3F800000);
    repeat (4) @(posedge clk);
    pulse_b(32'h40000000);
    @(negedge clk); check("start_not_on_capture", o_fpu_start, 0);
    @(negedge clk); check("start_one_after_capture", o_fpu_start, 1);
    check("t1_fpu_a", o_fpu_a, 32'h3F800000);
    check("t1_fpu_b", o_fpu_b, 32'h40000000);
    fpu_reply(3, 32'h40400000);
    wait_idle();
    @(posedge clk);
    check_log(8'h40, 8'h40, 8'h00, 8'h00);
    check("t1_start_pulses", cnt_start - s0, 1);
    check("t1_tx_pulses", cnt_txs - t0, 4);

    // simultaneous operands
    tx_log.delete(); s0 = cnt_start;
    pulse_ab(32'h11111111, 32'h22222222);
    wait_start();
    check("t2_fpu_a", o_fpu_a, 32'h11111111);
    check("t2_fpu_b", o_fpu_b, 32'h22222222);
    fpu_reply(2, 32'hC0A00000);
    wait_idle(); @(posedge clk);
    check_log(8'hC0, 8'hA0, 8'h00, 8'h00);
    check("t2_start_pulses", cnt_start - s0, 1);

    // B before A
    tx_log.delete(); s0 = cnt_start;
    pulse_b(32'h55555555);
    repeat (2) @(posedge clk);
    pulse_a(32'h66666666);
    wait_start();
    check("t3_fpu_a", o_fpu_a, 32'h66666666);
    check("t3_fpu_b", o_fpu_b, 32'h55555555);
    fpu_reply(1, 32'h12345678);
    wait_idle(); @(posedge clk);
    check_log(8'h12, 8'h34, 8'h56, 8'h78);
    check("t3_start_pulses", cnt_start - s0, 1);

    // repeated A overwrites silently
    tx_log.delete(); d0 = cnt_drop;
    pulse_a(32'hAAAA0000);
    pulse_a(32'hBBBB0000);
    pulse_b(32'h3F000000);
    wait_start();
    check("t4_fpu_a_overwritten", o_fpu_a, 32'hBBBB0000);
    fpu_reply(1, 32'h00000001);
    wait_idle(); @(posedge clk);
    check_log(8'h00, 8'h00, 8'h00, 8'h01);
    check("t4_no_drop", cnt_drop - d0, 0);

    // operand pulses during WAIT_FPU and WAIT_TX are dropped
    tx_log.delete(); d0 = cnt_drop;
    pulse_ab(32'h00000001, 32'h00000002);
    wait_start();
    repeat (2) @(posedge clk);
    pulse_a(32'hDEAD0000);
    fpu_reply(2, 32'hCAFEF00D);
    wait_txs();
    pulse_b(32'hBEEF0000);
    wait_idle(); @(posedge clk);
    check_log(8'hCA, 8'hFE, 8'hF0, 8'h0D);
    check("t5_drop_pulses", cnt_drop - d0, 2);
    check("t5_fpu_a_kept", o_fpu_a, 32'h00000001);
    check("t5_fpu_b_kept", o_fpu_b, 32'h00000002);
    s0 = cnt_start;
    pulse_a(32'h3F800000);
    repeat (8) @(posedge clk);
    check("t5_needs_fresh_b", cnt_start - s0, 0);
    tx_log.delete();
    pulse_b(32'h3F800000);
    wait_start();
    fpu_reply(1, 32'h3F800000);
    wait_idle(); @(posedge clk);
    check_log(8'h3F, 8'h80, 8'h00, 8'h00);

    // FPU timeout: start cycle plus 16 waiting cycles
    t0 = cnt_txs; o0 = cnt_to;
    pulse_ab(32'h00000001, 32'h00000002);
    wait_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!o_timeout && n < 40);
    check("timeout_latency", n, 17);
    check("timeout_busy_low", o_busy, 0);
    repeat (3) @(posedge clk);
    check("timeout_no_tx", cnt_txs - t0, 0);
    check("timeout_pulses", cnt_to - o0, 1);

    // valid on the limit cycle wins
    tx_log.delete(); o0 = cnt_to;
    pulse_ab(32'h00000003, 32'h00000004);
    wait_start();
    fpu_reply(TO, 32'hA1B2C3D4);
    wait_idle(); @(posedge clk);
    check_log(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    check("limit_no_timeout", cnt_to - o0, 0);

    // reset after the second byte is acked
    pulse_ab(32'h00000005, 32'h00000006);
    wait_start();
    fpu_reply(1, 32'h11223344);
    nd = 0; n = 0;
    do begin @(negedge clk); n++; if (tx_done) nd++; end while (nd < 2 && n < 100);
    check("two_acks_seen", nd, 2);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_tx_start", o_tx_start, 0);
    check("midrst_tx_data", o_tx_data, 0);
    check("midrst_fpu_a", o_fpu_a, 0);
    check("midrst_fpu_b", o_fpu_b, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    tx_log.delete(); s0 = cnt_start;
    pulse_ab(32'h40490FDB, 32'h3F800000);
    wait_start();
    check("post_rst_fpu_a", o_fpu_a, 32'h40490FDB);
    check("post_rst_fpu_b", o_fpu_b, 32'h3F800000);
    fpu_reply(2, 32'h40490FDB);
    wait_idle(); @(posedge clk);
    check_log(8'h40, 8'h49, 8'h0F, 8'hDB);
    check("post_rst_start_pulses", cnt_start - s0, 1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
